// File: rtl/channel_scan_seq.sv
// channel_scan_seq
// Round-robin channel scanner. Sweeps the channels enabled in ch_mask, holding
// each one for max(dwell,1) cycles, and drives a 2-to-4 decoder select/enable.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin scanning (honoured only in IDLE, non-empty mask, no stop)
//   stop     in   abort scanning (priority over start)
//   ch_mask  in   [3:0] per-channel enable
//   dwell    in   [DWELL_W-1:0] cycles per channel (0 behaves as 1)
//   sel      out  [1:0] registered active channel index
//   sel_en   out  registered decoder enable
//   busy     out  registered, high while scanning
//   wrap     out  registered one-cycle pulse on sweep wrap-around
module channel_scan_seq #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [1:0]         r_sel;
    logic [1:0]         w_sel_nxt;
    logic               r_sel_en;
    logic               w_sel_en_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;

    logic               w_mask_any;
    logic               w_launch;
    logic               w_expire;
    logic [DWELL_W-1:0] w_dwell_ld;
    logic [1:0]         w_first_ch;
    logic [1:0]         w_adv_ch;

    // First set bit of mask at or above 'from', searching upward modulo 4.
    function automatic logic [1:0] f_next_ch(input logic [3:0] mask, input logic [1:0] from);
        logic [1:0] idx;
        f_next_ch = from;
        for (int k = 3; k >= 0; k--) begin
            idx = from + 2'(k);
            if (mask[idx]) begin
                f_next_ch = idx;
            end
        end
    endfunction

    assign w_mask_any = |ch_mask;
    assign w_launch   = start && !stop && w_mask_any;
    assign w_expire   = (r_cnt == '0);
    // Counter is loaded with hold-length minus one, so dwell=0 still holds one cycle.
    assign w_dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign w_first_ch = f_next_ch(ch_mask, 2'd0);
    assign w_adv_ch   = f_next_ch(ch_mask, r_sel + 2'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (stop || (w_expire && !w_mask_any)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_sel_nxt    = r_sel;
        w_sel_en_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_sel_nxt    = w_first_ch;
                    w_sel_en_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = w_dwell_ld;
                end
            end
            S_SCAN: begin
                if (stop) begin
                    w_cnt_nxt = '0;
                end else if (w_expire) begin
                    if (w_mask_any) begin
                        w_sel_nxt    = w_adv_ch;
                        w_sel_en_nxt = 1'b1;
                        w_busy_nxt   = 1'b1;
                        // Single-channel mask gives adv == sel, which also counts as a wrap.
                        w_wrap_nxt   = (w_adv_ch <= r_sel);
                        w_cnt_nxt    = w_dwell_ld;
                    end
                end else begin
                    w_sel_en_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = r_cnt - DWELL_W'(1);
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Registered outputs and dwell counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel    <= 2'b00;
            r_sel_en <= 1'b0;
            r_busy   <= 1'b0;
            r_wrap   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sel    <= w_sel_nxt;
            r_sel_en <= w_sel_en_nxt;
            r_busy   <= w_busy_nxt;
            r_wrap   <= w_wrap_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign sel    = r_sel;
    assign sel_en = r_sel_en;
    assign busy   = r_busy;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_channel_scan_seq.sv
// Directed testbench for channel_scan_seq; expected values are hand-computed.
module tb_channel_scan_seq;

    localparam int unsigned DWELL_W = 8;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic [3:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
    logic               sel_en;
    logic               busy;
    logic               wrap;

    int n_checks;
    int n_fail;

    channel_scan_seq #(.DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .ch_mask (ch_mask),
        .dwell   (dwell),
        .sel     (sel),
        .sel_en  (sel_en),
        .busy    (busy),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] e_sel, input logic e_en,
                       input logic e_busy, input logic e_wrap);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {sel, sel_en, busy, wrap};
        exp = {e_sel, e_en, e_busy, e_wrap};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: sel/sel_en/busy/wrap observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_scan(input string tag, input logic [1:0] e_sel, input logic e_wrap);
        chk(tag, e_sel, 1'b1, 1'b1, e_wrap);
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] e_sel);
        chk(tag, e_sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        ch_mask  = 4'b0000;
        dwell    = '0;

        // Reset state
        #2;
        chk_idle("reset", 2'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("idle_after_reset", 2'd0);

        // Full sweep, mask 1111, dwell 2
        ch_mask = 4'b1111;
        dwell   = 8'd2;
        start   = 1'b1;
        tick(); chk_scan("sweep_c0a", 2'd0, 1'b0);
        start = 1'b0;
        tick(); chk_scan("sweep_c0b", 2'd0, 1'b0);
        tick(); chk_scan("sweep_c1a", 2'd1, 1'b0);
        tick(); chk_scan("sweep_c1b", 2'd1, 1'b0);
        tick(); chk_scan("sweep_c2a", 2'd2, 1'b0);
        tick(); chk_scan("sweep_c2b", 2'd2, 1'b0);
        tick(); chk_scan("sweep_c3a", 2'd3, 1'b0);
        tick(); chk_scan("sweep_c3b", 2'd3, 1'b0);
        tick(); chk_scan("sweep_wrap", 2'd0, 1'b1);
        tick(); chk_scan("sweep_c0_2nd", 2'd0, 1'b0);
        tick(); chk_scan("sweep_c1_2nd", 2'd1, 1'b0);
        stop = 1'b1;
        tick(); chk_idle("sweep_stop", 2'd1);
        stop = 1'b0;
        tick(); chk_idle("sweep_stop_hold", 2'd1);

        // Sparse mask 1010, dwell 3; start during SCAN is ignored
        ch_mask = 4'b1010;
        dwell   = 8'd3;
        start   = 1'b1;
        tick(); chk_scan("sparse_c1a", 2'd1, 1'b0);
        start = 1'b0;
        tick(); chk_scan("sparse_c1b", 2'd1, 1'b0);
        tick(); chk_scan("sparse_c1c", 2'd1, 1'b0);
        tick(); chk_scan("sparse_c3a", 2'd3, 1'b0);
        start = 1'b1;
        tick(); chk_scan("sparse_start_ign", 2'd3, 1'b0);
        start = 1'b0;
        tick(); chk_scan("sparse_c3c", 2'd3, 1'b0);
        tick(); chk_scan("sparse_wrap", 2'd1, 1'b1);
        tick(); chk_scan("sparse_c1_2nd", 2'd1, 1'b0);
        stop = 1'b1;
        tick(); chk_idle("sparse_stop", 2'd1);
        stop = 1'b0;

        // Single channel, dwell 0; then dwell change mid-channel
        ch_mask = 4'b0100;
        dwell   = 8'd0;
        start   = 1'b1;
        tick(); chk_scan("d0_first", 2'd2, 1'b0);
        start = 1'b0;
        tick(); chk_scan("d0_wrap1", 2'd2, 1'b1);
        tick(); chk_scan("d0_wrap2", 2'd2, 1'b1);
        dwell = 8'd3;
        tick(); chk_scan("d3_entry", 2'd2, 1'b1);
        dwell = 8'd0;
        tick(); chk_scan("dchg_hold1", 2'd2, 1'b0);
        tick(); chk_scan("dchg_hold2", 2'd2, 1'b0);
        tick(); chk_scan("dchg_expire", 2'd2, 1'b1);
        tick(); chk_scan("d0_wrap3", 2'd2, 1'b1);
        stop = 1'b1;
        tick(); chk_idle("d0_stop", 2'd2);
        stop = 1'b0;

        // Stop mid-dwell in the 3rd cycle of channel 1, then start with empty mask
        ch_mask = 4'b1111;
        dwell   = 8'd5;
        start   = 1'b1;
        tick(); chk_scan("stop_c0", 2'd0, 1'b0);
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick(); chk_scan("stop_c1a", 2'd1, 1'b0);
        tick();
        tick(); chk_scan("stop_c1c", 2'd1, 1'b0);
        stop = 1'b1;
        tick(); chk_idle("stop_mid", 2'd1);
        stop    = 1'b0;
        ch_mask = 4'b0000;
        start   = 1'b1;
        tick(); chk_idle("start_mask0", 2'd1);
        tick(); chk_idle("start_mask0_b", 2'd1);
        start = 1'b0;

        // Clearing the active channel's bit does not shorten it; skipped next sweep
        ch_mask = 4'b0011;
        dwell   = 8'd2;
        start   = 1'b1;
        tick(); chk_scan("clr_c0a", 2'd0, 1'b0);
        start   = 1'b0;
        ch_mask = 4'b0010;
        tick(); chk_scan("clr_c0b", 2'd0, 1'b0);
        tick(); chk_scan("clr_c1a", 2'd1, 1'b0);
        tick(); chk_scan("clr_c1b", 2'd1, 1'b0);
        tick(); chk_scan("clr_skip0", 2'd1, 1'b1);
        stop = 1'b1;
        tick(); chk_idle("clr_stop", 2'd1);
        stop = 1'b0;

        // Mask collapse during channel 2; then start+stop together
        ch_mask = 4'b1111;
        dwell   = 8'd2;
        start   = 1'b1;
        tick(); chk_scan("coll_c0", 2'd0, 1'b0);
        start = 1'b0;
        tick();
        tick();
        tick();
        tick(); chk_scan("coll_c2a", 2'd2, 1'b0);
        ch_mask = 4'b0000;
        tick(); chk_scan("coll_c2b", 2'd2, 1'b0);
        tick(); chk_idle("coll_idle", 2'd2);
        ch_mask = 4'b1111;
        start   = 1'b1;
        stop    = 1'b1;
        tick(); chk_idle("start_stop", 2'd2);
        tick(); chk_idle("start_stop_b", 2'd2);
        start = 1'b0;
        stop  = 1'b0;

        // Asynchronous reset mid-scan
        start = 1'b1;
        tick(); chk_scan("ar_c0", 2'd0, 1'b0);
        start = 1'b0;
        tick();
        tick(); chk_scan("ar_c1", 2'd1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("ar_immediate", 2'd0);
        tick(); chk_idle("ar_held", 2'd0);
        rst_n = 1'b1;
        tick(); chk_idle("ar_released", 2'd0);
        tick(); chk_idle("ar_wait", 2'd0);

        // start held across reset release is honoured at the first edge
        rst_n = 1'b0;
        #2;
        ch_mask = 4'b0100;
        dwell   = 8'd1;
        start   = 1'b1;
        rst_n   = 1'b1;
        tick(); chk_scan("rel_start", 2'd2, 1'b0);
        start = 1'b0;
        tick(); chk_scan("rel_wrap", 2'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_scan_seq.md
CHANNEL_SCAN_SEQ -- requirements
Module: channel_scan_seq

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-count input and internal dwell counter.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  level-sampled request to begin scanning; acted on only in IDLE.
REQ-006 Port: stop  input  1  level-sampled request to abort scanning.
REQ-007 Port: ch_mask  input  4  per-channel scan enable; bit i = channel i included.
REQ-008 Port: dwell  input  DWELL_W  cycles each channel is held, unsigned.
REQ-009 Port: sel  output  2  registered index of the active channel; drives the 2-to-4 decoder select.
REQ-010 Port: sel_en  output  1  registered enable; drives the decoder enable.
REQ-011 Port: busy  output  1  high whenever the FSM is in SCAN.
REQ-012 Port: wrap  output  1  one-cycle pulse marking completion of a full sweep.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SCAN.
REQ-014 In IDLE: sel_en=0, busy=0, wrap=0, and sel holds its last value.
REQ-015 IDLE->SCAN transition:
- Condition: start=1, stop=0 and ch_mask!=0 at a rising edge.
- Result from the next cycle: sel = lowest-numbered set bit of ch_mask, sel_en=1, busy=1.
REQ-016 start with ch_mask==0 SHALL be ignored; the FSM stays in IDLE.
REQ-017 start while in SCAN SHALL be ignored; the scan is not restarted.
REQ-018 Dwell time: each channel is held for max(dwell,1) cycles, so dwell=0 behaves as 1.
- dwell is sampled when a channel is entered.
- A change to dwell mid-channel SHALL NOT affect the current channel.
REQ-019 Channel advance on dwell expiry:
- sel moves to the next set bit of ch_mask, searching upward from sel+1 modulo 4.
- ch_mask is sampled at the advance edge.
- There are no idle cycles between channels; sel_en stays 1.
REQ-020 wrap behaviour:
- wrap SHALL pulse high for exactly one cycle, coincident with the first cycle of the new channel, whenever the new index is <= the previous index.
- With a single enabled channel, wrap pulses at every dwell expiry and sel is unchanged.
REQ-021 If ch_mask==0 at an advance edge, the FSM SHALL go to IDLE: sel_en=0, busy=0, wrap=0 from the next cycle.
REQ-022 stop=1 in SCAN SHALL force IDLE at the next edge regardless of the dwell count.
- No wrap pulse is produced.
- sel_en falls one cycle after stop is sampled.
REQ-023 start and stop high together SHALL leave or return the FSM in IDLE; stop has priority.
REQ-024 Clearing a mask bit for the currently active channel SHALL NOT shorten its dwell; it is skipped on the next sweep.
REQ-025 sel and sel_en SHALL change only on clock edges and SHALL be glitch-free registered outputs.
REQ-026 The block SHALL never present sel_en=1 with sel pointing to a channel that was not set in ch_mask at entry.

Reset
REQ-027 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, set:
- state=IDLE, sel=2'b00, sel_en=0, busy=0, wrap=0, dwell counter=0.
REQ-028 Reset asserted mid-scan SHALL abort the sweep; after deassertion the block waits in IDLE for a new start.
REQ-029 Release of rst_n SHALL take effect at the first rising edge after deassertion; start high at that edge is honoured.

Verification
REQ-030 Full sweep: ch_mask=4'b1111, dwell=2, start pulsed ->
- sel 0,0,1,1,2,2,3,3,0,... with sel_en=1 throughout.
- wrap high on the first cycle of the second sel=0.
REQ-031 Sparse mask: ch_mask=4'b1010, dwell=3 ->
- sel 1,1,1,3,3,3,1,...
- wrap on re-entry to channel 1.
REQ-032 dwell=0 with ch_mask=4'b0100 -> sel=2 constant, sel_en=1, wrap high every cycle after the first.
REQ-033 stop mid-dwell: ch_mask=4'b1111, dwell=5, stop in the 3rd cycle of channel 1 -> sel_en=0 and busy=0 next cycle, no wrap; start with ch_mask=0 afterwards leaves the block in IDLE.
REQ-034 Mask collapse: ch_mask cleared to 0 during channel 2 -> channel 2 completes its dwell, then IDLE; start and stop high together -> remains IDLE.
REQ-035 Async reset: rst_n driven low between clock edges during SCAN -> sel=0, sel_en=0, busy=0 immediately; the block resumes only on a new start.
